// File: rtl/dispram_pkg.sv
// Shared constants, FSM state encoding and command payload for the display RAM writer.
package dispram_pkg;

    localparam int unsigned H_RES  = 640;
    localparam int unsigned V_RES  = 480;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned X_W    = 10;
    localparam int unsigned Y_W    = 9;
    localparam int unsigned SPAN_W = 11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        DONE,
        ERR
    } state_e;

    typedef struct packed {
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [X_W-1:0]    w;
        logic [Y_W-1:0]    h;
        logic [DATA_W-1:0] color;
    } cmd_t;

    // Length of [org, org+len) that survives clipping to [0, lim).
    function automatic logic [SPAN_W-1:0] clip_span(input logic [SPAN_W-1:0] org,
                                                    input logic [SPAN_W-1:0] len,
                                                    input logic [SPAN_W-1:0] lim);
        logic [SPAN_W-1:0] room;
        room = lim - org;
        if (org >= lim) begin
            return '0;
        end else if (len > room) begin
            return room;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/dispram_addr_gen.sv
// Row-major write address walker: shift-add base address, column/row counters, end-of-row stride.
module dispram_addr_gen
    import dispram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic [X_W-1:0]    w,
    input  logic [Y_W-1:0]    h,
    output logic [ADDR_W-1:0] addr,
    output logic              last_col,
    output logic              last_row
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [X_W-1:0]    col_q, col_d;
    logic [Y_W-1:0]    row_q, row_d;
    logic [X_W-1:0]    w_q, w_d;
    logic [Y_W-1:0]    h_q, h_d;

    always_comb begin
        addr_d = addr_q;
        col_d  = col_q;
        row_d  = row_q;
        w_d    = w_q;
        h_d    = h_q;
        if (load) begin
            // y*640 as y*512 + y*128
            addr_d = (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7) + ADDR_W'(x);
            col_d  = '0;
            row_d  = '0;
            w_d    = w;
            h_d    = h;
        end else if (step) begin
            if (last_col) begin
                col_d  = '0;
                row_d  = row_q + Y_W'(1);
                addr_d = addr_q + ADDR_W'(H_RES) - ADDR_W'(w_q) + ADDR_W'(1);
            end else begin
                col_d  = col_q + X_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
            w_q    <= '0;
            h_q    <= '0;
        end else begin
            addr_q <= addr_d;
            col_q  <= col_d;
            row_q  <= row_d;
            w_q    <= w_d;
            h_q    <= h_d;
        end
    end

    assign addr     = addr_q;
    assign last_col = (col_q == w_q - X_W'(1));
    assign last_row = (row_q == h_q - Y_W'(1));

endmodule

// File: rtl/dispram_writer.sv
// Rectangle-fill engine for the 640x480 display RAM write port.
// Define DISPRAM_WR_CLIP_EN to clip rectangles to the screen instead of rejecting them.
module dispram_writer
    import dispram_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [X_W-1:0]    cmd_x,
    input  logic [Y_W-1:0]    cmd_y,
    input  logic [X_W-1:0]    cmd_w,
    input  logic [Y_W-1:0]    cmd_h,
    input  logic [DATA_W-1:0] cmd_color,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              wea,
    output logic [ADDR_W-1:0] ramaddra,
    output logic [DATA_W-1:0] ramdina
);

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              wea_q, wea_d;
    logic [DATA_W-1:0] ramdina_q, ramdina_d;

    logic [X_W-1:0]    w_eff;
    logic [Y_W-1:0]    h_eff;
    logic              reject;
    logic              load, step;
    logic              last_col, last_row;

    // Effective rectangle size and bounds rule, evaluated while in SETUP
    always_comb begin
`ifdef DISPRAM_WR_CLIP_EN
        w_eff  = X_W'(clip_span(SPAN_W'(cmd_q.x), SPAN_W'(cmd_q.w), SPAN_W'(H_RES)));
        h_eff  = Y_W'(clip_span(SPAN_W'(cmd_q.y), SPAN_W'(cmd_q.h), SPAN_W'(V_RES)));
        reject = 1'b0;
`else
        w_eff  = cmd_q.w;
        h_eff  = cmd_q.h;
        reject = ((SPAN_W'(cmd_q.x) + SPAN_W'(cmd_q.w)) > SPAN_W'(H_RES)) ||
                 ((10'(cmd_q.y) + 10'(cmd_q.h)) > 10'(V_RES));
`endif
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    cmd_d.x     = cmd_x;
                    cmd_d.y     = cmd_y;
                    cmd_d.w     = cmd_w;
                    cmd_d.h     = cmd_h;
                    cmd_d.color = cmd_color;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                if (reject) begin
                    state_d = ERR;
                end else if (w_eff == '0 || h_eff == '0) begin
                    state_d = DONE;
                end else begin
                    state_d = WRITE;
                    load    = 1'b1;
                end
            end
            WRITE: begin
                if (last_col && last_row) begin
                    state_d = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state implies
        cmd_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        err_d       = (state_d == ERR);
        wea_d       = (state_d == WRITE);
        ramdina_d   = load ? cmd_q.color : ramdina_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wea_q       <= 1'b0;
            ramdina_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wea_q       <= wea_d;
            ramdina_q   <= ramdina_d;
        end
    end

    dispram_addr_gen u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .x        (cmd_q.x),
        .y        (cmd_q.y),
        .w        (w_eff),
        .h        (h_eff),
        .addr     (ramaddra),
        .last_col (last_col),
        .last_row (last_row)
    );

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign wea       = wea_q;
    assign ramdina   = ramdina_q;

endmodule

// File: tb/tb_dispram_writer.sv
// Directed bench for dispram_writer: write traces checked against hand values and a row-major model.
module tb_dispram_writer;
    import dispram_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [X_W-1:0]    cmd_x;
    logic [Y_W-1:0]    cmd_y;
    logic [X_W-1:0]    cmd_w;
    logic [Y_W-1:0]    cmd_h;
    logic [DATA_W-1:0] cmd_color;
    logic              busy, done, err, wea;
    logic [ADDR_W-1:0] ramaddra;
    logic [DATA_W-1:0] ramdina;

    int n_checks = 0;
    int n_fail   = 0;

    int wr_addr[$];
    int wr_data[$];
    int wr_off[$];
    int done_off, err_off, done_cnt, err_cnt;

    always #5 clk = ~clk;

    dispram_writer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .wea       (wea),
        .ramaddra  (ramaddra),
        .ramdina   (ramdina)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int x, input int y, input int w, input int h, input int c);
        cmd_x     = X_W'(x);
        cmd_y     = Y_W'(y);
        cmd_w     = X_W'(w);
        cmd_h     = Y_W'(h);
        cmd_color = DATA_W'(c);
    endtask

    task automatic log_cycle(input int off);
        if (wea) begin
            wr_addr.push_back(int'(ramaddra));
            wr_data.push_back(int'(ramdina));
            wr_off.push_back(off);
        end
        if (done) begin
            done_cnt++;
            if (done_off < 0) done_off = off;
        end
        if (err) begin
            err_cnt++;
            if (err_off < 0) err_off = off;
        end
    endtask

    task automatic clear_log;
        wr_addr.delete();
        wr_data.delete();
        wr_off.delete();
        done_off = -1;
        err_off  = -1;
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    // Offsets count cycles from the accept edge: offset 1 is the SETUP cycle.
    task automatic run_cmd(input int x, input int y, input int w, input int h, input int c,
                           input int limit);
        clear_log();
        check("ready_before", 32'(cmd_ready), 1);
        drive(x, y, w, h, c);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("busy_setup", 32'(busy), 1);
        check("wea_setup", 32'(wea), 0);
        for (int off = 2; off <= limit; off++) begin
            tick();
            log_cycle(off);
            if (done_off >= 0 || err_off >= 0) break;
        end
        check("finished_in_budget", 32'(done_off >= 0 || err_off >= 0), 1);
        tick();
        check("ready_after", 32'(cmd_ready), 1);
        check("pulse_one_cycle", 32'(done | err), 0);
    endtask

    task automatic verify(input string tag, input int x, input int y, input int w, input int h,
                          input int c);
        int we, he, rej, k;
`ifdef DISPRAM_WR_CLIP_EN
        we  = (x >= 640) ? 0 : ((w < 640 - x) ? w : 640 - x);
        he  = (y >= 480) ? 0 : ((h < 480 - y) ? h : 480 - y);
        rej = 0;
`else
        we  = w;
        he  = h;
        rej = ((x + w > 640) || (y + h > 480)) ? 1 : 0;
`endif
        if (rej != 0) begin
            check({tag, "_err_off"}, 32'(err_off), 2);
            check({tag, "_nwr"}, 32'(wr_addr.size()), 0);
            check({tag, "_ndone"}, 32'(done_cnt), 0);
        end else begin
            check({tag, "_nwr"}, 32'(wr_addr.size()), 32'(we * he));
            check({tag, "_nerr"}, 32'(err_cnt), 0);
            check({tag, "_done_off"}, 32'(done_off), 32'(2 + we * he));
            k = 0;
            for (int r = 0; r < he; r++) begin
                for (int col = 0; col < we; col++) begin
                    if (k < wr_addr.size()) begin
                        check({tag, "_addr"}, 32'(wr_addr[k]), 32'((y + r) * 640 + x + col));
                        check({tag, "_data"}, 32'(wr_data[k]), 32'(c));
                        check({tag, "_off"}, 32'(wr_off[k]), 32'(2 + k));
                    end
                    k++;
                end
            end
        end
    endtask

    initial begin
        int cnt, acc, dn2;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (3) tick();
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_wea", 32'(wea), 0);
        check("rst_addr", 32'(ramaddra), 0);
        check("rst_data", 32'(ramdina), 0);
        rst = 1'b0;
        tick();

        // 3x2 box at (10,2)
        run_cmd(10, 2, 3, 2, 'hF00, 40);
        verify("box", 10, 2, 3, 2, 'hF00);
        check("box_first", 32'(wr_addr[0]), 1290);
        check("box_row_end", 32'(wr_addr[2]), 1292);
        check("box_row2", 32'(wr_addr[3]), 1930);
        check("box_last", 32'(wr_addr[5]), 1932);
        check("box_done8", 32'(done_off), 8);

        // Three full-width lines from the origin
        run_cmd(0, 0, 640, 3, 'h000, 2000);
        verify("wide", 0, 0, 640, 3, 'h000);
        check("wide_last", 32'(wr_addr[1919]), 1919);

        // Bottom-right corner block ending at the last pixel
        run_cmd(600, 470, 40, 10, 'h5A5, 600);
        verify("corner", 600, 470, 40, 10, 'h5A5);
        check("corner_last", 32'(wr_addr[399]), 307199);

        // Zero-size commands
        run_cmd(3, 4, 0, 5, 'h123, 20);
        verify("w0", 3, 4, 0, 5, 'h123);
        check("w0_done2", 32'(done_off), 2);
        run_cmd(7, 8, 9, 0, 'h321, 20);
        verify("h0", 7, 8, 9, 0, 'h321);

        // Crosses both right and bottom edges
        run_cmd(638, 479, 4, 2, 'h0F0, 20);
        verify("edge", 638, 479, 4, 2, 'h0F0);
`ifdef DISPRAM_WR_CLIP_EN
        check("edge_a0", 32'(wr_addr[0]), 307198);
        check("edge_a1", 32'(wr_addr[1]), 307199);
        check("edge_done", 32'(done_off), 4);
`else
        check("edge_err2", 32'(err_off), 2);
        check("edge_nowr", 32'(wr_addr.size()), 0);
`endif

        // Reset asserted during the 5th write of a 3x3 fill
        clear_log();
        drive(5, 1, 3, 3, 'h00F);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cnt = 0;
        for (int off = 2; off < 20 && cnt < 5; off++) begin
            tick();
            if (wea) cnt++;
        end
        check("rstmid_reached5", 32'(cnt), 5);
        rst = 1'b1;
        tick();
        check("rstmid_wea", 32'(wea), 0);
        check("rstmid_ready", 32'(cmd_ready), 1);
        check("rstmid_done", 32'(done), 0);
        rst = 1'b0;
        cnt = 0;
        repeat (12) begin
            tick();
            if (done || wea || err) cnt++;
        end
        check("rstmid_quiet", 32'(cnt), 0);
        run_cmd(10, 2, 3, 2, 'hF00, 40);
        verify("after_rst", 10, 2, 3, 2, 'hF00);

        // Two commands with cmd_valid held high
        clear_log();
        drive(0, 0, 2, 1, 'h00A);
        cmd_valid = 1'b1;
        tick();
        drive(100, 3, 1, 2, 'h00B);
        acc = -1;
        dn2 = -1;
        for (int off = 2; off <= 20; off++) begin
            tick();
            if (acc >= 0 && off == acc + 1) cmd_valid = 1'b0;
            if (done && done_off >= 0 && dn2 < 0) dn2 = off;
            log_cycle(off);
            if (cmd_ready && cmd_valid && acc < 0) acc = off;
        end
        cmd_valid = 1'b0;
        check("b2b_done1", 32'(done_off), 4);
        check("b2b_accept", 32'(acc), 32'(done_off + 1));
        check("b2b_nwr", 32'(wr_addr.size()), 4);
        check("b2b_a0", 32'(wr_addr[0]), 0);
        check("b2b_a1", 32'(wr_addr[1]), 1);
        check("b2b_a2", 32'(wr_addr[2]), 2020);
        check("b2b_a3", 32'(wr_addr[3]), 2660);
        check("b2b_d2", 32'(wr_data[2]), 'h00B);
        check("b2b_off2", 32'(wr_off[2]), 32'(acc + 2));
        check("b2b_done2", 32'(dn2), 32'(acc + 4));
        check("b2b_ndone", 32'(done_cnt), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dispram_writer.md
# dispram_writer

Write-side engine for the 640x480, 12-bit RGB display RAM. Accepts rectangle-fill commands over a valid/ready handshake and drives the RAM write port (port A) one pixel per clock, row-major. The display scan logic reads the same RAM on port B independently. This block makes screen clears, menu boxes and highlight bars pure command traffic for the vending-machine UI controller.

## Interface
Parameters:
- H_RES, 640, visible pixels per line; also the RAM row stride
- V_RES, 480, visible lines
- ADDR_W, 19, RAM address width
- DATA_W, 12, pixel width (RGB 4:4:4)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_x  in  10  left column
- cmd_y  in  9  top line
- cmd_w  in  10  width in pixels
- cmd_h  in  9  height in lines
- cmd_color  in  DATA_W  fill colour
- busy  out  1  high from the cycle after accept until the DONE cycle inclusive
- done  out  1  one-cycle pulse when a command finishes (including zero-pixel commands)
- err  out  1  one-cycle pulse when a command is rejected (only without clipping)
- wea  out  1  RAM write enable
- ramaddra  out  ADDR_W  RAM write address, y*H_RES + x
- ramdina  out  DATA_W  RAM write data

## Operation
- Accept: cmd_valid && cmd_ready latches all cmd_* fields; cmd_ready is low in every state except IDLE.
- FSM states: IDLE -> SETUP -> WRITE -> DONE -> IDLE. SETUP -> DONE if the effective width or height is 0. SETUP -> ERR -> IDLE on rejection.
- SETUP (1 cycle): apply the bounds rule (see Configuration). Compute the base address as (y<<9)+(y<<7)+x using shift-add, with no multiplier.
- WRITE: wea=1 every cycle, ramdina=colour, ramaddra = current address.
  - Column counter counts 0..w-1. Within a row the address increments by 1.
  - At row end the address advances by H_RES-w+1 and the row counter increments.
  - After the last pixel of row h-1, go to DONE.
- DONE: done=1 for one cycle. ERR: err=1 for one cycle.
- Outputs outside WRITE: wea=0. ramaddra and ramdina hold their last values and are don't-care.
- Reset values: cmd_ready=1, busy=0, done=0, err=0, wea=0, ramaddra=0, ramdina=0, state=IDLE.
- Reset mid-command: wea drops on the next edge and the command is abandoned. No done or err. Pixels already written stay written.
- Arithmetic: address math in ADDR_W bits. Bounds checks use x+w and y+h at 11/10 bits so they cannot overflow.

## Timing
- Accept at edge N. SETUP occupies cycle N+1. The first write has wea=1 in cycle N+2.
- Pixel k (0-based, row-major) is written in cycle N+2+k. DONE is in cycle N+2+w*h.
- cmd_ready returns high in cycle N+3+w*h, so back-to-back throughput is w*h+3 cycles per command.
- Zero-size command: done in cycle N+2. Rejected command: err in cycle N+2.
- Max command (full screen): 307200 write cycles.

## Configuration
- DISPRAM_WR_CLIP_EN defined: the rectangle is clipped to [0,H_RES)x[0,V_RES).
  - Effective w = min(w, H_RES-x), or 0 if x>=H_RES. Height is clipped the same way.
  - err never asserts.
- Undefined: any command with x+w>H_RES or y+h>V_RES is rejected via ERR with no writes.

## Structure
- Shared package dispram_pkg holds:
  - H_RES, V_RES, ADDR_W, DATA_W
  - the state enum (IDLE, SETUP, WRITE, DONE, ERR)
  - a cmd struct {x, y, w, h, color}
- One sub-module, dispram_addr_gen: holds the base-address shift-add, the row/column counters and the end-of-row stride step. It outputs the address plus last_col/last_row flags.
- The FSM and handshake stay in the top.

## Test plan
- Fill x=10,y=2,w=3,h=2,colour 0xF00. Expect writes in 6 consecutive cycles to addresses 1290,1291,1292,1930,1931,1932 with data 0xF00. done occurs 8 cycles after accept.
- Full-screen clear, colour 0x000. Expect 307200 writes, first address 0, last address 307199, with no gaps.
- w=0 (any h). Expect no wea, done 2 cycles after accept, cmd_ready high the following cycle.
- x=638,w=4,y=479,h=2:
  - with DISPRAM_WR_CLIP_EN: writes to 307198 and 307199 only, then done.
  - without: err pulse and no wea.
- Assert rst during the 5th write of a 3x3 fill. Expect wea=0 the next cycle, cmd_ready=1, no done. A new command is then accepted normally.
- Hold cmd_valid high with two queued commands. Expect the second accept exactly in the cycle after the first command's DONE.
